// File: rtl/e203_itcm_icb_arbt_if.sv
// ICB point-to-point bundle: command channel from master, response channel back.
// No storage; pure wiring between an ICB master and an ICB slave.
// Backpressure: valid/ready on both the cmd and the rsp channel.
interface e203_itcm_icb_arbt_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/e203_itcm_icb_arbt.sv
// Two-master (IFU/LSU) ICB arbiter onto the single ITCM port, in-order response routing, IFU holdup flag.
// Latency: zero-cycle command pass-through; responses routed combinationally from the ITCM.
// Backpressure: cmds stall when OUTS_DP commands are outstanding; ITCM rsp stalls on the owning master's rsp_ready.
module e203_itcm_icb_arbt #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int OUTS_DP    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    e203_itcm_icb_arbt_if.slave          ifu2itcm_icb,
    e203_itcm_icb_arbt_if.slave          lsu2itcm_icb,
    e203_itcm_icb_arbt_if.master         itcm_icb,
    output logic                         ifu2itcm_holdup
);

    localparam int PW = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;
    localparam int CW = $clog2(OUTS_DP + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Source-ID FIFO: one bit per outstanding command, 1 = LSU owns it.
    logic [OUTS_DP-1:0] src_q;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic [SW-1:0]      starve_cnt;

    logic cmd_ok;
    logic ifu_pri;
    logic gnt_lsu;
    logic gnt_ifu;
    logic cmd_hsk;
    logic ifu_hsk;
    logic lsu_hsk;
    logic fifo_empty;
    logic head_lsu;
    logic rsp_hsk;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_DP - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant and command mux: LSU wins unless the IFU has been starved long enough.
    always_comb begin
        cmd_ok   = (cnt != CW'(OUTS_DP));
        ifu_pri  = (starve_cnt == SW'(STARVE_MAX));
        gnt_lsu  = lsu2itcm_icb.cmd_valid & ~(ifu_pri & ifu2itcm_icb.cmd_valid);
        gnt_ifu  = ifu2itcm_icb.cmd_valid & ~gnt_lsu;

        itcm_icb.cmd_valid = cmd_ok & (gnt_lsu | gnt_ifu);
        itcm_icb.cmd_addr  = gnt_lsu ? lsu2itcm_icb.cmd_addr  : ifu2itcm_icb.cmd_addr;
        itcm_icb.cmd_read  = gnt_lsu ? lsu2itcm_icb.cmd_read  : 1'b1;
        itcm_icb.cmd_wdata = gnt_lsu ? lsu2itcm_icb.cmd_wdata : '0;
        itcm_icb.cmd_wmask = gnt_lsu ? lsu2itcm_icb.cmd_wmask : '0;

        ifu2itcm_icb.cmd_ready = gnt_ifu & cmd_ok & itcm_icb.cmd_ready;
        lsu2itcm_icb.cmd_ready = gnt_lsu & cmd_ok & itcm_icb.cmd_ready;

        cmd_hsk = itcm_icb.cmd_valid & itcm_icb.cmd_ready;
        ifu_hsk = cmd_hsk & gnt_ifu;
        lsu_hsk = cmd_hsk & gnt_lsu;
    end

    // Response routing by the owner recorded at the FIFO head; err/rdata go to both masters.
    always_comb begin
        fifo_empty = (cnt == '0);
        head_lsu   = src_q[rd_ptr];

        ifu2itcm_icb.rsp_valid = itcm_icb.rsp_valid & ~fifo_empty & ~head_lsu;
        lsu2itcm_icb.rsp_valid = itcm_icb.rsp_valid & ~fifo_empty &  head_lsu;
        ifu2itcm_icb.rsp_err   = itcm_icb.rsp_err;
        lsu2itcm_icb.rsp_err   = itcm_icb.rsp_err;
        ifu2itcm_icb.rsp_rdata = itcm_icb.rsp_rdata;
        lsu2itcm_icb.rsp_rdata = itcm_icb.rsp_rdata;

        itcm_icb.rsp_ready = ~fifo_empty &
                             (head_lsu ? lsu2itcm_icb.rsp_ready : ifu2itcm_icb.rsp_ready);
        rsp_hsk = itcm_icb.rsp_valid & itcm_icb.rsp_ready;
    end

    // Source-ID FIFO: push on ITCM cmd handshake, pop on ITCM rsp handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (cmd_hsk) begin
                src_q[wr_ptr] <= gnt_lsu;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (rsp_hsk) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({cmd_hsk, rsp_hsk})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Anti-starvation: count LSU wins while the IFU is waiting, clear once the IFU gets in.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (ifu_hsk) begin
            starve_cnt <= '0;
        end else if (lsu_hsk && ifu2itcm_icb.cmd_valid && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Holdup: ITCM read port still shows the last IFU data until any new command is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifu2itcm_holdup <= 1'b0;
        end else if (cmd_hsk) begin
            ifu2itcm_holdup <= 1'b0;
        end else if (rsp_hsk && !head_lsu) begin
            ifu2itcm_holdup <= 1'b1;
        end
    end

    // A response with nothing outstanding means the ITCM broke the in-order protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(itcm_icb.rsp_valid && fifo_empty));
        end
    end

endmodule
